// File: rtl/integral_image_writer.sv
// -----------------------------------------------------------------------------
// integral_image_writer
//
// Computes the integral image of one raster-scanned grayscale frame and writes
// it to the single-port RAM read by the Haar classifier stage. It keeps one
// running row sum and one row of line buffer, and issues one RAM write per
// accepted pixel, one cycle after the handshake. After the last word has been
// committed it pulses frame_done.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start              one-cycle pulse; begins a frame (honoured only in IDLE)
//   s_valid, s_pixel   pixel stream, raster order
//   s_ready            writer accepts a pixel (registered state decode)
//   bram_ena/wea       RAM enable / write enable
//   bram_addr          write address, x + y*IMG_WIDTH
//   bram_din           integral value
//   busy               high from start acceptance until frame_done
//   frame_done         one-cycle pulse, all words committed
// -----------------------------------------------------------------------------
module integral_image_writer #(
    parameter int IMG_WIDTH  = 20,
    parameter int IMG_HEIGHT = 20,
    parameter int PIX_W      = 8,
    parameter int DATA_W     = 17,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_pixel,
    output logic              s_ready,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [DATA_W-1:0]   row_sum_q, row_sum_d;
    logic                s_ready_q, s_ready_d;
    logic                bram_ena_q, bram_ena_d;
    logic                bram_wea_q, bram_wea_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_din_q, bram_din_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    // Previous row's integral values, indexed by column. Never cleared: row 0
    // masks the read, so stale contents from an aborted frame are harmless.
    logic [DATA_W-1:0]   line_buf_q [IMG_WIDTH];
    logic [DATA_W-1:0]   line_buf_d [IMG_WIDTH];

    logic                hs;
    logic                x_last, y_last;
    logic [DATA_W-1:0]   row_sum_new;
    logic [DATA_W-1:0]   above;
    logic [DATA_W-1:0]   ii;
    logic [ADDR_W-1:0]   pix_addr;

    always_comb begin
        // s_ready_q mirrors state RUN, so it doubles as the accept condition.
        hs          = s_ready_q && s_valid;
        x_last      = (x_q == XW'(IMG_WIDTH - 1));
        y_last      = (y_q == YW'(IMG_HEIGHT - 1));
        row_sum_new = ((x_q == '0) ? '0 : row_sum_q) + DATA_W'(s_pixel);
        above       = (y_q == '0) ? '0 : line_buf_q[x_q];
        ii          = row_sum_new + above;
        pix_addr    = ADDR_W'(x_q) + ADDR_W'(y_q) * ADDR_W'(IMG_WIDTH);

        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_sum_d  = row_sum_q;
        line_buf_d = line_buf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = '0;
                    y_d       = '0;
                    row_sum_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (hs) begin
                    row_sum_d      = row_sum_new;
                    line_buf_d[x_q] = ii;
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            state_d = S_FLUSH;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One-cycle write latency; address/data hold when no write is issued.
        bram_ena_d   = hs;
        bram_wea_d   = hs;
        bram_addr_d  = hs ? pix_addr : bram_addr_q;
        bram_din_d   = hs ? ii : bram_din_q;

        // Outputs registered from the next state so they line up with it.
        s_ready_d    = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            row_sum_q    <= '0;
            s_ready_q    <= 1'b0;
            bram_ena_q   <= 1'b0;
            bram_wea_q   <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_sum_q    <= row_sum_d;
            s_ready_q    <= s_ready_d;
            bram_ena_q   <= bram_ena_d;
            bram_wea_q   <= bram_wea_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign s_ready    = s_ready_q;
    assign bram_ena   = bram_ena_q;
    assign bram_wea   = bram_wea_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
